serial_fs: RTL and testbench

Bit-serial full subtractor. It computes a − b − bin on WIDTH-bit operands one bit per clock, LSB first, through a single 1-bit full-subtractor cell and a registered borrow. It complements the team's combinational full-adder datapath with a low-area subtract path that uses a start/done handshake. Cascading several units through `bin`/`borrow_out` forms wider subtractions.

---
 rtl/serial_fs.sv | 119 +++++++++++
 tb/tb_serial_fs.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/serial_fs.sv
// serial_fs: bit-serial a - b - bin, one bit per clock LSB first, start/done handshake.
// Optional feature macro: SERIAL_FS_OVF_EN adds the signed-overflow output ovf.

module serial_fs_cell (
  input  logic x,
  input  logic y,
  input  logic br,
  output logic d,
  output logic br_next
);
  assign d       = x ^ y ^ br;
  assign br_next = (~x & y) | (~x & br) | (y & br);
endmodule

module serial_fs #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_FS_OVF_EN
  output logic             ovf,
`endif
  output logic             borrow_out
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] opa, opb, opa_nx;
  logic             br, d, br_nx;
  logic [CW-1:0]    cnt;

  serial_fs_cell u_cell (
    .x      (opa[0]),
    .y      (opb[0]),
    .br     (br),
    .d      (d),
    .br_next(br_nx)
  );

  // The minuend register doubles as the result register: each processed
  // bit vacates the LSB and the difference bit enters at the MSB.
  generate
    if (WIDTH == 1) begin : g_w1
      assign opa_nx = d;
    end else begin : g_wn
      assign opa_nx = {d, opa[WIDTH-1:1]};
    end
  endgenerate

`ifdef SERIAL_FS_OVF_EN
  logic sign_a, sign_b;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      opa        <= '0;
      opb        <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SERIAL_FS_OVF_EN
      sign_a     <= 1'b0;
      sign_b     <= 1'b0;
      ovf        <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            opa   <= a;
            opb   <= b;
            br    <= bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
`ifdef SERIAL_FS_OVF_EN
            sign_a <= a[WIDTH-1];
            sign_b <= b[WIDTH-1];
`endif
          end
        end
        RUN: begin
          opa <= opa_nx;
          opb <= opb >> 1;
          br  <= br_nx;
          if (cnt == LAST) begin
            diff       <= opa_nx;
            borrow_out <= br_nx;
            done       <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
`ifdef SERIAL_FS_OVF_EN
            // d is the result MSB on the final bit
            ovf        <= (sign_a ^ sign_b) & (sign_a ^ d);
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_fs.sv
// Self-checking bench for serial_fs: directed cases plus random jobs against an arithmetic model.
module tb_serial_fs;
  logic       clk, rst_n;
  logic       start, bin, busy, done, borrow_out;
  logic [7:0] a, b, diff;
  logic       s1_start, s1_a, s1_b, s1_bin, s1_busy, s1_done, s1_diff, s1_bo;
`ifdef SERIAL_FS_OVF_EN
  logic       ovf, s1_ovf;
`endif

  int         checks = 0;
  int         errors = 0;
  logic [7:0] prev_d;
  logic       prev_b;
`ifdef SERIAL_FS_OVF_EN
  logic       prev_o;
`endif

  serial_fs #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff),
`ifdef SERIAL_FS_OVF_EN
    .ovf(ovf),
`endif
    .borrow_out(borrow_out)
  );

  serial_fs #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(s1_start), .a(s1_a), .b(s1_b), .bin(s1_bin),
    .busy(s1_busy), .done(s1_done), .diff(s1_diff),
`ifdef SERIAL_FS_OVF_EN
    .ovf(s1_ovf),
`endif
    .borrow_out(s1_bo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Unsigned/signed arithmetic view of a - b - bin at width w.
  function automatic void model(input int w, input longint ua, input longint ub, input longint ubin,
                                output longint d, output bit bo, output bit ov);
    longint m, sa, sb, r;
    m  = longint'(1) << w;
    d  = (ua - ub - ubin) & (m - 1);
    bo = (ua < ub + ubin);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    r  = sa - sb - ubin;
    ov = (r < -(m / 2)) || (r > m / 2 - 1);
  endfunction

  task automatic idle(input int k);
    repeat (k) begin
      start = 1'b0;
      @(posedge clk); #1;
      chk("idle_done", done, 0);
      chk("idle_busy", busy, 0);
    end
  endtask

  // Called at #1 after an edge with busy=0; returns in the done cycle.
  task automatic do_job(input logic [7:0] ta, input logic [7:0] tbv, input logic tbin, input int inj);
    longint ed;
    bit     eb, eo;
    int     n;
    model(8, ta, tbv, tbin, ed, eb, eo);
    a = ta; b = tbv; bin = tbin; start = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      start = (n == inj);
      a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      chk("run_busy", busy, 1);
      chk("diff_hold", diff, prev_d);
      chk("bo_hold", borrow_out, prev_b);
`ifdef SERIAL_FS_OVF_EN
      chk("ovf_hold", ovf, prev_o);
`endif
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    chk("latency", n, 8);
    chk("done", done, 1);
    chk("busy_low", busy, 0);
    chk("diff", diff, 32'(ed));
    chk("borrow_out", borrow_out, eb);
    prev_d = 8'(ed);
    prev_b = eb;
`ifdef SERIAL_FS_OVF_EN
    chk("ovf", ovf, eo);
    prev_o = eo;
`endif
  endtask

  task automatic job1(input logic ta, input logic tbv, input logic tbin);
    longint ed;
    bit     eb, eo;
    model(1, ta, tbv, tbin, ed, eb, eo);
    s1_a = ta; s1_b = tbv; s1_bin = tbin; s1_start = 1'b1;
    @(posedge clk); #1;
    s1_start = 1'b0;
    chk("w1_busy", s1_busy, 1);
    chk("w1_nodone", s1_done, 0);
    @(posedge clk); #1;
    chk("w1_done", s1_done, 1);
    chk("w1_busy_low", s1_busy, 0);
    chk("w1_diff", s1_diff, 32'(ed));
    chk("w1_bo", s1_bo, eb);
`ifdef SERIAL_FS_OVF_EN
    chk("w1_ovf", s1_ovf, eo);
`endif
    @(posedge clk); #1;
    chk("w1_pulse", s1_done, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    s1_start = 1'b0; s1_a = 1'b0; s1_b = 1'b0; s1_bin = 1'b0;
    prev_d = '0; prev_b = 1'b0;
`ifdef SERIAL_FS_OVF_EN
    prev_o = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bo", borrow_out, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_job(8'd5, 8'd3, 1'b0, -1);
    chk("basic_diff", diff, 8'h02);
    idle(1);
    do_job(8'd3, 8'd5, 1'b0, -1);
    chk("under_diff", diff, 8'hFE);
    idle(2);
    do_job(8'd0, 8'd0, 1'b1, -1);
    chk("bin_diff", diff, 8'hFF);
    do_job(8'hA0, 8'h0F, 1'b0, -1);
    chk("b2b_diff", diff, 8'h91);
    idle(1);
    do_job(8'h80, 8'h01, 1'b0, -1);
    do_job(8'h10, 8'h01, 1'b0, -1);
    idle(1);

    // start pulsed mid-job is ignored
    do_job(8'($urandom), 8'($urandom), 1'($urandom), 3);
    idle(1);

    // reset mid-job aborts
    a = 8'h5A; b = 8'h33; bin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_diff", diff, 0);
    chk("abort_bo", borrow_out, 0);
`ifdef SERIAL_FS_OVF_EN
    chk("abort_ovf", ovf, 0);
    prev_o = 1'b0;
`endif
    prev_d = '0; prev_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    for (int i = 0; i < 40; i++) begin
      do_job(8'($urandom), 8'($urandom), 1'($urandom), -1);
      idle($urandom_range(0, 2));
    end
    idle(1);

    job1(1'b0, 1'b1, 1'b0);
    chk("w1_dir_diff", s1_diff, 1);
    chk("w1_dir_bo", s1_bo, 1);
    for (int i = 0; i < 8; i++) job1(1'(i >> 2), 1'(i >> 1), 1'(i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
